// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor D = X - Y, one full-subtractor step per clock, LSB first.
// Define SERIAL_SUB_OVF_EN to add the registered signed-overflow output V.
module serial_subtractor #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    output logic [WIDTH-1:0] D,
    output logic             Bo,
    output logic             busy,
    output logic             done
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             V
`endif
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] xs;
    logic [WIDTH-1:0] ys;
    logic [WIDTH-1:0] r;
    logic             b;
    logic [CW-1:0]    cnt;

    logic             di_c;
    logic             b_next_c;
    logic [WIDTH-1:0] r_next_c;

`ifdef SERIAL_SUB_OVF_EN
    logic             xm;
    logic             ym;
`endif

    // Full-subtractor cell on the current LSBs; result bits enter r from the top.
    assign di_c     = xs[0] ^ ys[0] ^ b;
    assign b_next_c = (~xs[0] & ys[0]) | (~(xs[0] ^ ys[0]) & b);
    assign r_next_c = WIDTH'({di_c, r} >> 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            xs    <= '0;
            ys    <= '0;
            r     <= '0;
            b     <= 1'b0;
            cnt   <= '0;
            D     <= '0;
            Bo    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            xm    <= 1'b0;
            ym    <= 1'b0;
            V     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        xs    <= X;
                        ys    <= Y;
                        b     <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
`ifdef SERIAL_SUB_OVF_EN
                        xm    <= X[WIDTH-1];
                        ym    <= Y[WIDTH-1];
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    xs  <= xs >> 1;
                    ys  <= ys >> 1;
                    r   <= r_next_c;
                    b   <= b_next_c;
                    cnt <= CW'(cnt + 1'b1);
                    // Last bit: publish the full result in one shot.
                    if (cnt == CW'(WIDTH - 1)) begin
                        D     <= r_next_c;
                        Bo    <= b_next_c;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
`ifdef SERIAL_SUB_OVF_EN
                        V     <= (xm ^ ym) & (xm ^ di_c);
`endif
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor at WIDTH=4.
module tb_serial_subtractor;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] X;
    logic [W-1:0] Y;
    logic [W-1:0] D;
    logic         Bo;
    logic         busy;
    logic         done;
`ifdef SERIAL_SUB_OVF_EN
    logic         V;
`endif

    int n_checks = 0;
    int n_err    = 0;

    logic [W-1:0] last_d  = '0;
    logic         last_bo = 1'b0;
    logic         last_v  = 1'b0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .X     (X),
        .Y     (Y),
        .D     (D),
        .Bo    (Bo),
        .busy  (busy),
        .done  (done)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .V     (V)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_v(input string tag, input logic ev);
`ifdef SERIAL_SUB_OVF_EN
        chk({tag, ".V"}, 32'(V), 32'(ev));
`else
        if (ev === 1'bx) $display("unused %s", tag);
`endif
    endtask

    // One full operation from idle; checks the busy window, the done cycle and the hold after.
    task automatic do_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [W-1:0] ed, input logic eb, input logic ev);
        X = x; Y = y; start = 1'b1;
        step();
        start = 1'b0;
        X = W'($urandom); Y = W'($urandom);
        for (int k = 0; k < int'(W); k++) begin
            chk({tag, ".busy"}, 32'(busy), 32'd1);
            chk({tag, ".done_early"}, 32'(done), 32'd0);
            chk({tag, ".D_hold"}, 32'(D), 32'(last_d));
            step();
        end
        chk({tag, ".done"}, 32'(done), 32'd1);
        chk({tag, ".busy_off"}, 32'(busy), 32'd0);
        chk({tag, ".D"}, 32'(D), 32'(ed));
        chk({tag, ".Bo"}, 32'(Bo), 32'(eb));
        chk_v(tag, ev);
        last_d = ed; last_bo = eb; last_v = ev;
        step();
        chk({tag, ".done_pulse"}, 32'(done), 32'd0);
        chk({tag, ".idle_busy"}, 32'(busy), 32'd0);
        chk({tag, ".D_after"}, 32'(D), 32'(ed));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; X = '0; Y = '0;
        step();
        chk("rst.D", 32'(D), 32'd0);
        chk("rst.Bo", 32'(Bo), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk_v("rst", 1'b0);
        rst = 1'b0;
        step();

        // Basic vectors: (X, Y) -> D, Bo, V
        do_op("op9_3",  4'd9,  4'd3,  4'd6,  1'b0, 1'b1);
        do_op("op3_9",  4'd3,  4'd9,  4'd10, 1'b1, 1'b1);
        do_op("op15_15",4'd15, 4'd15, 4'd0,  1'b0, 1'b0);
        do_op("op0_1",  4'd0,  4'd1,  4'd15, 1'b1, 1'b0);
        do_op("op8_1",  4'd8,  4'd1,  4'd7,  1'b0, 1'b1);
        do_op("op7_15", 4'd7,  4'd15, 4'd8,  1'b1, 1'b1);
        do_op("op5_3",  4'd5,  4'd3,  4'd2,  1'b0, 1'b0);

        // Start during busy is ignored
        X = 4'd5; Y = 4'd2; start = 1'b1;
        step();
        start = 1'b0;
        step();
        X = 4'd1; Y = 4'd1; start = 1'b1;
        step();
        start = 1'b0;
        chk("ign.busy", 32'(busy), 32'd1);
        step();
        chk("ign.busy2", 32'(busy), 32'd1);
        step();
        chk("ign.done", 32'(done), 32'd1);
        chk("ign.D", 32'(D), 32'd3);
        chk("ign.Bo", 32'(Bo), 32'd0);
        chk_v("ign", 1'b0);
        last_d = 4'd3;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("ign.no_done", 32'(done), 32'd0);
            chk("ign.no_busy", 32'(busy), 32'd0);
        end
        chk("ign.D_hold", 32'(D), 32'd3);

        // Back-to-back with start held high: (12-5), (2-7), (10-10)
        X = 4'd12; Y = 4'd5; start = 1'b1;
        step();
        X = 4'd2; Y = 4'd7;
        for (int k = 0; k < int'(W); k++) begin
            chk("b2b0.busy", 32'(busy), 32'd1);
            step();
        end
        chk("b2b0.done", 32'(done), 32'd1);
        chk("b2b0.busy_off", 32'(busy), 32'd0);
        chk("b2b0.D", 32'(D), 32'd7);
        chk("b2b0.Bo", 32'(Bo), 32'd0);
        chk_v("b2b0", 1'b1);
        step();
        X = 4'd10; Y = 4'd10;
        for (int k = 0; k < int'(W); k++) begin
            chk("b2b1.busy", 32'(busy), 32'd1);
            chk("b2b1.done_low", 32'(done), 32'd0);
            step();
        end
        chk("b2b1.done", 32'(done), 32'd1);
        chk("b2b1.busy_off", 32'(busy), 32'd0);
        chk("b2b1.D", 32'(D), 32'd11);
        chk("b2b1.Bo", 32'(Bo), 32'd1);
        chk_v("b2b1", 1'b0);
        step();
        X = 4'd0; Y = 4'd0;
        for (int k = 0; k < int'(W); k++) begin
            chk("b2b2.busy", 32'(busy), 32'd1);
            if (k == int'(W) - 1) start = 1'b0;
            step();
        end
        chk("b2b2.done", 32'(done), 32'd1);
        chk("b2b2.D", 32'(D), 32'd0);
        chk("b2b2.Bo", 32'(Bo), 32'd0);
        chk_v("b2b2", 1'b0);
        step();
        chk("b2b2.idle", 32'(busy), 32'd0);
        last_d = 4'd0;

        // Prime a nonzero D, then reset mid-operation
        do_op("pre_rst", 4'd14, 4'd3, 4'd11, 1'b0, 1'b0);
        X = 4'd6; Y = 4'd1; start = 1'b1;
        step();
        start = 1'b0;
        step();
        rst = 1'b1;
        #1;
        chk("mid_rst.D", 32'(D), 32'd0);
        chk("mid_rst.Bo", 32'(Bo), 32'd0);
        chk("mid_rst.busy", 32'(busy), 32'd0);
        chk("mid_rst.done", 32'(done), 32'd0);
        step();
        rst = 1'b0;
        last_d = '0;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("post_rst.done", 32'(done), 32'd0);
            chk("post_rst.busy", 32'(busy), 32'd0);
            chk("post_rst.D", 32'(D), 32'd0);
        end
        do_op("after_rst", 4'd6, 4'd1, 4'd5, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial N-bit subtractor computing D = X − Y, the inverse operation of the team's 4-bit ripple adder. It uses one full-subtractor cell and a registered borrow, processing one bit per clock, LSB first. A start/busy/done handshake controls it, and it is intended for area-constrained datapaths where a parallel subtractor is not justified.

## Interface
Parameters:
- WIDTH, default 4: operand and result width in bits; legal range WIDTH ≥ 2.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  reset; asynchronous, active-high.
- start  input  1  request; sampled only when idle (state IDLE or DONE).
- X  input  WIDTH  minuend; sampled on the accepting edge only.
- Y  input  WIDTH  subtrahend; sampled on the accepting edge only.
- D  output  WIDTH  difference, (X − Y) mod 2^WIDTH; registered, held until the next completion.
- Bo  output  1  final borrow; 1 iff X < Y unsigned; registered, held like D.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle completion pulse.
- V  output  1  signed overflow; present only with SERIAL_SUB_OVF_EN.

## Operation
- State machine with three states: IDLE, SHIFT, DONE.
- IDLE, start=1:
  - load X and Y into shift registers xs and ys;
  - clear the borrow flop b and the bit counter;
  - go to SHIFT.
- IDLE, start=0: stay in IDLE.
- SHIFT, every edge:
  - di = xs[0] ^ ys[0] ^ b.
  - b ← (~xs[0] & ys[0]) | (~(xs[0] ^ ys[0]) & b).
  - xs and ys shift right by one.
  - di shifts into the MSB of the internal result register r.
  - The counter increments.
- SHIFT, when the counter reaches WIDTH−1 (the last bit):
  - D ← final r, including this edge's di;
  - Bo ← next value of b;
  - go to DONE.
- DONE:
  - lasts exactly one cycle; done=1 and busy=0;
  - with start=1, accept a new operation exactly as IDLE does and go to SHIFT;
  - otherwise go to IDLE.
- start while in SHIFT is ignored; there is no queueing.
- X and Y may change freely after the accepting edge.
- D and Bo change only on the completion edge. Intermediate bits are never visible on D.
- busy = (state == SHIFT). done = (state == DONE).
- Unsigned arithmetic. Bo is the borrow out of the MSB; no carry-in or borrow-in port exists.

## Timing
- Accepting edge t0. busy=1 in the cycle after t0.
- WIDTH bit steps occur on edges t0+1 … t0+WIDTH.
- D, Bo, and V update on edge t0+WIDTH. In that same cycle done=1 and busy=0.
- Latency: WIDTH edges from the accepting edge to valid D.
- Back-to-back throughput: one operation per WIDTH+1 cycles, with start held high across DONE.
- Reset values: state IDLE; D=0, Bo=0, busy=0, done=0, V=0; xs, ys, r, b, and counter all 0.
- Reset asserted mid-operation:
  - the operation is aborted immediately;
  - D and Bo return to 0; the partial result is discarded;
  - after release, the first rising edge with start=1 is an accepting edge.

## Configuration
- SERIAL_SUB_OVF_EN defined:
  - output port V exists.
  - V = (X[WIDTH−1] ^ Y[WIDTH−1]) & (X[WIDTH−1] ^ D[WIDTH−1]), using operand MSBs latched at acceptance.
  - V is registered, updates with D, resets to 0, and is held until the next completion.
- SERIAL_SUB_OVF_EN undefined:
  - V port and all associated MSB-capture logic are absent.
  - All other behaviour is identical.

## Test plan
- WIDTH=4, X=9, Y=3, start pulsed one cycle -> busy high for 4 cycles; D=6, Bo=0, done=1 for exactly one cycle on edge t0+4.
- X=3, Y=9 -> D=10, Bo=1. Then X=15, Y=15 -> D=0, Bo=0. Then X=0, Y=1 -> D=15, Bo=1.
- Start with X=5, Y=2; pulse start again with X=1, Y=1 at t0+2 (during busy) -> second request ignored; D=3 at t0+4; no second done pulse.
- Start held high continuously with alternating operands -> done pulses every 5 cycles; each D matches its own operands; busy low only in the done cycles.
- Assert rst at t0+2, release, then idle -> D=0, Bo=0, busy=0, done=0; no done pulse; a new start after release gives the correct result.
- SERIAL_SUB_OVF_EN defined, X=8 (−8), Y=1 -> D=7, V=1. X=7, Y=15 (−1) -> D=8, V=1. X=5, Y=3 -> V=0.
